// File: rtl/exu_branch_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module   : exu_branch_resolve_if
//  Purpose  : Commit handshake bundle between the BJP unit (master) and the
//             branch-resolve stage (slave).
//  Signals  : cmt_i_valid/cmt_i_ready handshake, cmt_i_pc, cmt_i_imm,
//             cmt_i_rv32, and the instruction-type/prediction flags
//             cmt_i_bjp, cmt_i_prdt, cmt_i_rslv, cmt_i_mret, cmt_i_dret,
//             cmt_i_fencei.
//  Revision : 1.0 - initial release
// ============================================================================
interface exu_branch_resolve_if #(
   parameter int PC_SIZE = 32,
   parameter int XLEN    = 32
);
   logic                cmt_i_valid;
   logic                cmt_i_ready;
   logic [PC_SIZE-1:0]  cmt_i_pc;
   logic [XLEN-1:0]     cmt_i_imm;
   logic                cmt_i_rv32;
   logic                cmt_i_bjp;
   logic                cmt_i_prdt;
   logic                cmt_i_rslv;
   logic                cmt_i_mret;
   logic                cmt_i_dret;
   logic                cmt_i_fencei;

   modport master (
      output cmt_i_valid, cmt_i_pc, cmt_i_imm, cmt_i_rv32, cmt_i_bjp,
             cmt_i_prdt, cmt_i_rslv, cmt_i_mret, cmt_i_dret, cmt_i_fencei,
      input  cmt_i_ready
   );

   modport slave (
      input  cmt_i_valid, cmt_i_pc, cmt_i_imm, cmt_i_rv32, cmt_i_bjp,
             cmt_i_prdt, cmt_i_rslv, cmt_i_mret, cmt_i_dret, cmt_i_fencei,
      output cmt_i_ready
   );
endinterface
`default_nettype wire

// File: rtl/exu_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : exu_branch_resolve
//  Purpose  : Consumes resolved branches/jumps/MRET/DRET/FENCE.I from the BJP
//             commit interface, decides whether the front-end must be
//             flushed, computes and registers the redirect PC, and holds the
//             flush request toward the IFU until acknowledged. The commit
//             interface is back-pressured while a flush is outstanding.
//  Ports    : clk, rst (async, active-high)
//             cmt            - commit handshake (slave modport)
//             csr_mepc/dpc   - CSR sources for MRET/DRET targets
//             pipe_flush_req/ack/pc - flush handshake toward the IFU
//             cmt_*_ena      - one-cycle pulses on accepted MRET/DRET/FENCE.I
//             brslv_busy     - flush outstanding
//  Option   : BRSLV_PERF_CNT_EN adds perf_bjp_cnt / perf_mis_cnt counters.
//  Revision : 1.0 - initial release
// ============================================================================
module exu_branch_resolve #(
   parameter int PC_SIZE = 32,
   parameter int XLEN    = 32
) (
   input  logic                clk,
   input  logic                rst,
   exu_branch_resolve_if.slave cmt,
   input  logic [PC_SIZE-1:0]  csr_mepc,
   input  logic [PC_SIZE-1:0]  csr_dpc,
   output logic                pipe_flush_req,
   input  logic                pipe_flush_ack,
   output logic [PC_SIZE-1:0]  pipe_flush_pc,
   output logic                cmt_mret_ena,
   output logic                cmt_dret_ena,
   output logic                cmt_fencei_ena,
   output logic                brslv_busy
`ifdef BRSLV_PERF_CNT_EN
   ,
   output logic [31:0]         perf_bjp_cnt,
   output logic [31:0]         perf_mis_cnt
`endif
);

   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_flush = 1'b1;

   logic [0:0]          r_state;
   logic                r_flush_req;
   logic [PC_SIZE-1:0]  r_flush_pc;
   logic                r_mret_ena;
   logic                r_dret_ena;
   logic                r_fencei_ena;

   logic                w_ready;
   logic                w_accept;
   logic                w_mispredict;
   logic                w_flush_need;
   logic [PC_SIZE-1:0]  w_target;

   // Ready depends on the state register only, so there is no
   // combinational loop through cmt_i_valid.
   assign w_ready          = (r_state == c_st_idle);
   assign cmt.cmt_i_ready  = w_ready;
   assign w_accept         = cmt.cmt_i_valid & w_ready;

   assign w_mispredict = cmt.cmt_i_bjp & (cmt.cmt_i_prdt ^ cmt.cmt_i_rslv);
   assign w_flush_need = cmt.cmt_i_dret | cmt.cmt_i_mret | cmt.cmt_i_fencei
                       | w_mispredict;

   // Redirect target, dret > mret > fencei > bjp. All sums wrap silently.
   always_comb begin
      w_target = '0;
      if (cmt.cmt_i_dret) begin
         w_target = csr_dpc;
      end else if (cmt.cmt_i_mret) begin
         w_target = csr_mepc;
      end else if (cmt.cmt_i_fencei) begin
         w_target = cmt.cmt_i_pc + PC_SIZE'(4);
      end else if (cmt.cmt_i_rslv) begin
         w_target = cmt.cmt_i_pc + cmt.cmt_i_imm[PC_SIZE-1:0];
      end else begin
         w_target = cmt.cmt_i_pc + (cmt.cmt_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
      end
   end

   // Flush FSM. Request and target are frozen while in FLUSH; only the
   // ack can move the machine back to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_st_idle;
         r_flush_req <= 1'b0;
         r_flush_pc  <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept && w_flush_need) begin
                  r_state     <= c_st_flush;
                  r_flush_req <= 1'b1;
                  r_flush_pc  <= w_target;
               end
            end
            c_st_flush: begin
               if (pipe_flush_ack) begin
                  r_state     <= c_st_idle;
                  r_flush_req <= 1'b0;
               end
            end
            default: begin
               r_state     <= c_st_idle;
               r_flush_req <= 1'b0;
            end
         endcase
      end
   end

   // Type pulses fire on acceptance regardless of whether a flush follows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mret_ena   <= 1'b0;
         r_dret_ena   <= 1'b0;
         r_fencei_ena <= 1'b0;
      end else begin
         r_mret_ena   <= w_accept & cmt.cmt_i_mret;
         r_dret_ena   <= w_accept & cmt.cmt_i_dret;
         r_fencei_ena <= w_accept & cmt.cmt_i_fencei;
      end
   end

   assign pipe_flush_req  = r_flush_req;
   assign pipe_flush_pc   = r_flush_pc;
   assign cmt_mret_ena    = r_mret_ena;
   assign cmt_dret_ena    = r_dret_ena;
   assign cmt_fencei_ena  = r_fencei_ena;
   assign brslv_busy      = (r_state == c_st_flush);

`ifdef BRSLV_PERF_CNT_EN
   logic [31:0] r_bjp_cnt;
   logic [31:0] r_mis_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bjp_cnt <= '0;
         r_mis_cnt <= '0;
      end else begin
         if (w_accept && cmt.cmt_i_bjp) begin
            r_bjp_cnt <= r_bjp_cnt + 32'd1;
         end
         if (w_accept && w_mispredict) begin
            r_mis_cnt <= r_mis_cnt + 32'd1;
         end
      end
   end

   assign perf_bjp_cnt = r_bjp_cnt;
   assign perf_mis_cnt = r_mis_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exu_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exu_branch_resolve
//  Purpose  : Self-checking bench for exu_branch_resolve: a table of directed
//             commit vectors, hand-written reset/stray-ack sequences, and
//             randomized commits checked against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exu_branch_resolve;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] csr_mepc;
   logic [31:0] csr_dpc;
   logic        pipe_flush_req;
   logic        pipe_flush_ack;
   logic [31:0] pipe_flush_pc;
   logic        cmt_mret_ena;
   logic        cmt_dret_ena;
   logic        cmt_fencei_ena;
   logic        brslv_busy;
`ifdef BRSLV_PERF_CNT_EN
   logic [31:0] perf_bjp_cnt;
   logic [31:0] perf_mis_cnt;
   int          mdl_bjp;
   int          mdl_mis;
`endif

   exu_branch_resolve_if #(.PC_SIZE(32), .XLEN(32)) bus ();

   exu_branch_resolve #(.PC_SIZE(32), .XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmt            (bus.slave),
      .csr_mepc       (csr_mepc),
      .csr_dpc        (csr_dpc),
      .pipe_flush_req (pipe_flush_req),
      .pipe_flush_ack (pipe_flush_ack),
      .pipe_flush_pc  (pipe_flush_pc),
      .cmt_mret_ena   (cmt_mret_ena),
      .cmt_dret_ena   (cmt_dret_ena),
      .cmt_fencei_ena (cmt_fencei_ena),
      .brslv_busy     (brslv_busy)
`ifdef BRSLV_PERF_CNT_EN
      ,
      .perf_bjp_cnt   (perf_bjp_cnt),
      .perf_mis_cnt   (perf_mis_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        rv32, bjp, prdt, rslv, mret, dret, fencei;
      logic [31:0] mepc, dpc;
      logic        exp_flush;
      logic [31:0] exp_pc;
      int          ack_wait;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: flush decision and redirect target straight from the
   // instruction-type rules, using plain 32-bit arithmetic.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_flush = v.dret || v.mret || v.fencei || (v.bjp && (v.prdt != v.rslv));
      if (v.dret)        r.exp_pc = v.dpc;
      else if (v.mret)   r.exp_pc = v.mepc;
      else if (v.fencei) r.exp_pc = v.pc + 32'd4;
      else if (v.rslv)   r.exp_pc = v.pc + v.imm;
      else               r.exp_pc = v.pc + (v.rv32 ? 32'd4 : 32'd2);
      return r;
   endfunction

   task automatic clear_bus();
      bus.cmt_i_valid  = 1'b0;
      bus.cmt_i_pc     = '0;
      bus.cmt_i_imm    = '0;
      bus.cmt_i_rv32   = 1'b0;
      bus.cmt_i_bjp    = 1'b0;
      bus.cmt_i_prdt   = 1'b0;
      bus.cmt_i_rslv   = 1'b0;
      bus.cmt_i_mret   = 1'b0;
      bus.cmt_i_dret   = 1'b0;
      bus.cmt_i_fencei = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 with the DUT idle. Leaves it idle at posedge+1.
   task automatic do_commit(input vec_t v);
      logic [31:0] held_pc;
      chk({v.name, ".ready_pre"}, 32'(bus.cmt_i_ready), 32'd1);
      csr_mepc         = v.mepc;
      csr_dpc          = v.dpc;
      bus.cmt_i_valid  = 1'b1;
      bus.cmt_i_pc     = v.pc;
      bus.cmt_i_imm    = v.imm;
      bus.cmt_i_rv32   = v.rv32;
      bus.cmt_i_bjp    = v.bjp;
      bus.cmt_i_prdt   = v.prdt;
      bus.cmt_i_rslv   = v.rslv;
      bus.cmt_i_mret   = v.mret;
      bus.cmt_i_dret   = v.dret;
      bus.cmt_i_fencei = v.fencei;
`ifdef BRSLV_PERF_CNT_EN
      if (v.bjp) mdl_bjp++;
      if (v.bjp && (v.prdt != v.rslv)) mdl_mis++;
`endif
      tick();
      clear_bus();
      chk({v.name, ".req"},    32'(pipe_flush_req), 32'(v.exp_flush));
      chk({v.name, ".busy"},   32'(brslv_busy),     32'(v.exp_flush));
      chk({v.name, ".ready"},  32'(bus.cmt_i_ready), 32'(!v.exp_flush));
      chk({v.name, ".mret"},   32'(cmt_mret_ena),   32'(v.mret));
      chk({v.name, ".dret"},   32'(cmt_dret_ena),   32'(v.dret));
      chk({v.name, ".fencei"}, 32'(cmt_fencei_ena), 32'(v.fencei));
      if (v.exp_flush) chk({v.name, ".pc"}, pipe_flush_pc, v.exp_pc);
      held_pc = pipe_flush_pc;
      if (v.exp_flush) begin
         // Perturb CSRs and offer a junk commit; all must be ignored.
         csr_mepc         = ~v.mepc;
         csr_dpc          = v.dpc + 32'h100;
         bus.cmt_i_valid  = 1'b1;
         bus.cmt_i_mret   = 1'b1;
         bus.cmt_i_bjp    = 1'b1;
         bus.cmt_i_prdt   = 1'b1;
         bus.cmt_i_pc     = 32'hDEAD_0000;
      end
      tick();
      chk({v.name, ".pulse_end"}, {29'd0, cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena}, 32'd0);
      if (v.exp_flush) begin
         for (int i = 0; i < v.ack_wait; i++) begin
            chk({v.name, ".hold_req"}, 32'(pipe_flush_req), 32'd1);
            chk({v.name, ".hold_rdy"}, 32'(bus.cmt_i_ready), 32'd0);
            tick();
         end
         chk({v.name, ".hold_pc"}, pipe_flush_pc, held_pc);
         pipe_flush_ack = 1'b1;
         tick();
         pipe_flush_ack = 1'b0;
         clear_bus();
         chk({v.name, ".ack_req"},  32'(pipe_flush_req), 32'd0);
         chk({v.name, ".ack_rdy"},  32'(bus.cmt_i_ready), 32'd1);
         chk({v.name, ".ack_busy"}, 32'(brslv_busy), 32'd0);
         chk({v.name, ".no_junk"},  32'(cmt_mret_ena), 32'd0);
      end
   endtask

   vec_t tbl[10];
   vec_t rv;

   initial begin
      //             name        pc            imm          r32 bjp prd rsl mrt drt fnc mepc      dpc       flush exp_pc       wait
      tbl[0] = '{"mis_taken",  32'h8000_0100, 32'h40,      1, 1, 0, 1, 0, 0, 0, 32'h0,    32'h0,    1, 32'h8000_0140, 1};
      tbl[1] = '{"mis_nt16",   32'h200,       32'h0,       0, 1, 1, 0, 0, 0, 0, 32'h0,    32'h0,    1, 32'h202,       0};
      tbl[2] = '{"correct",    32'h300,       32'h10,      1, 1, 1, 1, 0, 0, 0, 32'h0,    32'h0,    0, 32'h0,         0};
      tbl[3] = '{"mret",       32'h400,       32'h0,       1, 0, 0, 0, 1, 0, 0, 32'h1234, 32'h0,    1, 32'h1234,      2};
      tbl[4] = '{"dret_bjp",   32'h400,       32'h20,      1, 1, 0, 1, 0, 1, 0, 32'h0,    32'h800,  1, 32'h800,       1};
      tbl[5] = '{"wrap",       32'hFFFF_FFFC, 32'h8,       1, 1, 0, 1, 0, 0, 0, 32'h0,    32'h0,    1, 32'h4,         0};
      tbl[6] = '{"fencei",     32'h1000,      32'h0,       1, 0, 0, 0, 0, 0, 1, 32'h0,    32'h0,    1, 32'h1004,      3};
      tbl[7] = '{"none",       32'h1100,      32'h0,       1, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0,    0, 32'h0,         0};
      tbl[8] = '{"mis_nt32",   32'h500,       32'hFFFF_FFF0, 1, 1, 1, 0, 0, 0, 0, 32'h0,  32'h0,    1, 32'h504,       1};
      tbl[9] = '{"mret_fencei",32'h10,        32'h0,       1, 0, 0, 0, 1, 0, 1, 32'h2000, 32'h0,    1, 32'h2000,      0};

      clear_bus();
      csr_mepc = '0;
      csr_dpc = '0;
      pipe_flush_ack = 1'b0;
`ifdef BRSLV_PERF_CNT_EN
      mdl_bjp = 0;
      mdl_mis = 0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.req",   32'(pipe_flush_req), 32'd0);
      chk("rst.pc",    pipe_flush_pc, 32'd0);
      chk("rst.busy",  32'(brslv_busy), 32'd0);
      chk("rst.ena",   {29'd0, cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst.ready", 32'(bus.cmt_i_ready), 32'd1);

      foreach (tbl[i]) do_commit(tbl[i]);

      // Stray ack while idle.
      pipe_flush_ack = 1'b1;
      tick();
      pipe_flush_ack = 1'b0;
      chk("stray.ready", 32'(bus.cmt_i_ready), 32'd1);
      chk("stray.req",   32'(pipe_flush_req), 32'd0);
      chk("stray.busy",  32'(brslv_busy), 32'd0);

      // Reset in the middle of an outstanding flush.
      bus.cmt_i_valid = 1'b1;
      bus.cmt_i_pc    = 32'h3000;
      bus.cmt_i_imm   = 32'h80;
      bus.cmt_i_rv32  = 1'b1;
      bus.cmt_i_bjp   = 1'b1;
      bus.cmt_i_rslv  = 1'b1;
      tick();
      clear_bus();
      chk("rstmid.req_before", 32'(pipe_flush_req), 32'd1);
      chk("rstmid.pc_before",  pipe_flush_pc, 32'h3080);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid.req_async", 32'(pipe_flush_req), 32'd0);
      chk("rstmid.pc_clear",  pipe_flush_pc, 32'd0);
      tick();
      rst = 1'b0;
`ifdef BRSLV_PERF_CNT_EN
      mdl_bjp = 0;
      mdl_mis = 0;
`endif
      tick();
      chk("rstmid.ready", 32'(bus.cmt_i_ready), 32'd1);
      chk("rstmid.req",   32'(pipe_flush_req), 32'd0);

      // Five branches, two of them mispredicted.
      for (int i = 0; i < 5; i++) begin
         rv = '{"perf", 32'h6000 + 32'(i * 16), 32'h100, 1, 1, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0};
         if (i == 1 || i == 3) rv.prdt = 1'b0;
         do_commit(model(rv));
      end
`ifdef BRSLV_PERF_CNT_EN
      chk("perf.bjp5", perf_bjp_cnt, 32'd5);
      chk("perf.mis2", perf_mis_cnt, 32'd2);
`endif

      // Randomized commits against the reference model.
      for (int n = 0; n < 80; n++) begin
         rv.name   = "rand";
         rv.pc     = $urandom();
         rv.imm    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed(12'($urandom())));
         rv.rv32   = 1'($urandom_range(0, 1));
         rv.bjp    = 1'($urandom_range(0, 1));
         rv.prdt   = 1'($urandom_range(0, 1));
         rv.rslv   = 1'($urandom_range(0, 1));
         rv.mret   = ($urandom_range(0, 5) == 0);
         rv.dret   = ($urandom_range(0, 7) == 0);
         rv.fencei = ($urandom_range(0, 6) == 0);
         rv.mepc   = $urandom();
         rv.dpc    = $urandom();
         rv.ack_wait = $urandom_range(0, 3);
         do_commit(model(rv));
         repeat ($urandom_range(0, 2)) begin
            tick();
            chk("rand.idle_rdy", 32'(bus.cmt_i_ready), 32'd1);
         end
      end
`ifdef BRSLV_PERF_CNT_EN
      chk("perf.bjp_total", perf_bjp_cnt, 32'(mdl_bjp));
      chk("perf.mis_total", perf_mis_cnt, 32'(mdl_mis));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/exu_branch_resolve.md
Name: exu_branch_resolve

Overview:
- Commit-side consumer of the BJP unit's commit interface; sits directly downstream of the branch/jump ALU path.
- Accepts one resolved branch, jump, MRET, DRET or FENCE.I per handshake and decides whether the front-end must be flushed.
- Computes the redirect PC, registers it, and holds a flush request toward the IFU until it is acknowledged.
- Back-pressures the commit interface while a flush is outstanding.

Parameters:
- PC_SIZE, 32, width of all PC/target paths.
- XLEN, 32, width of the immediate input.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- cmt_i_valid  in  1  commit request from the BJP unit.
- cmt_i_ready  out  1  commit accepted. High only in IDLE.
- cmt_i_pc  in  PC_SIZE  PC of the committing instruction.
- cmt_i_imm  in  XLEN  branch offset, sign-extended.
- cmt_i_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit instruction.
- cmt_i_bjp  in  1  conditional branch or jump.
- cmt_i_prdt  in  1  predicted taken.
- cmt_i_rslv  in  1  resolved taken.
- cmt_i_mret  in  1  MRET.
- cmt_i_dret  in  1  DRET.
- cmt_i_fencei  in  1  FENCE.I.
- csr_mepc  in  PC_SIZE  current MEPC.
- csr_dpc  in  PC_SIZE  current DPC.
- pipe_flush_req  out  1  flush request to the IFU (registered).
- pipe_flush_ack  in  1  IFU accepts the flush.
- pipe_flush_pc  out  PC_SIZE  redirect target (registered).
- cmt_mret_ena  out  1  one-cycle pulse when an MRET is accepted.
- cmt_dret_ena  out  1  one-cycle pulse when a DRET is accepted.
- cmt_fencei_ena  out  1  one-cycle pulse when a FENCE.I is accepted.
- brslv_busy  out  1  flush outstanding (state == FLUSH).

Behaviour:
- Reset values: state = IDLE; pipe_flush_req = 0; pipe_flush_pc = 0; all *_ena = 0; brslv_busy = 0.
- cmt_i_ready = (state == IDLE). It is combinational from the state register only, with no path from cmt_i_valid.
- Accept condition: cmt_i_valid & cmt_i_ready.
- Flush is needed if any of: dret | mret | fencei | (bjp & (prdt ^ rslv)).
- Target priority when multiple type bits are set: dret > mret > fencei > bjp.
  - dret: csr_dpc.
  - mret: csr_mepc.
  - fencei: pc + 4.
  - bjp with rslv = 1: pc + imm[PC_SIZE-1:0].
  - bjp with rslv = 0: pc + (rv32 ? 4 : 2).
- All additions are modulo 2^PC_SIZE; wrap-around is silent.
- CSR values are sampled in the accept cycle.
- *_ena pulses: asserted for exactly the cycle after acceptance of the matching instruction. Registered, independent of the flush state.
- Correctly predicted bjp (prdt == rslv) and an accept with no type bits set: consumed in one cycle, no flush, state stays IDLE.
- State machine: IDLE, FLUSH.
  - IDLE -> FLUSH on accept with flush needed. In that same edge, load pipe_flush_pc and set pipe_flush_req = 1.
  - Latency: the flush request is visible the cycle after acceptance.
  - FLUSH -> IDLE on pipe_flush_ack. pipe_flush_req clears at that edge, and cmt_i_ready is high the following cycle.
  - While in FLUSH, pipe_flush_req and pipe_flush_pc are held stable. CSR and input changes are ignored.
- pipe_flush_ack while in IDLE is ignored.
- Back-to-back case: a second flush-causing commit can be accepted at the earliest one cycle after the ack.
- Reset asserted mid-FLUSH: the request drops immediately (async); the pending target is discarded.

Optional Feature:
- Macro: BRSLV_PERF_CNT_EN.
- When defined, add output ports perf_bjp_cnt (32 bits) and perf_mis_cnt (32 bits).
  - perf_bjp_cnt increments on every accepted bjp.
  - perf_mis_cnt increments on every accepted bjp with prdt ^ rslv.
  - Both reset to 0, wrap from 0xFFFFFFFF to 0, and update one cycle after acceptance.
- When undefined, the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Mispredicted taken branch: pc = 0x8000_0100, imm = 0x40, prdt = 0, rslv = 1, accepted at cycle N -> pipe_flush_req = 1 and pipe_flush_pc = 0x8000_0140 at N+1; cmt_i_ready = 0 until the ack; ack at N+3 -> req = 0 at N+4 and ready = 1 at N+4.
- Mispredicted not-taken branch: rv32 = 0, pc = 0x200, prdt = 1, rslv = 0 -> pipe_flush_pc = 0x202. Correct prediction (prdt = rslv = 1) -> no request, ready stays 1.
- MRET with csr_mepc = 0x1234 -> cmt_mret_ena pulses exactly one cycle and pipe_flush_pc = 0x1234. csr_mepc changed during FLUSH -> pipe_flush_pc stays 0x1234.
- Simultaneous dret and bjp set, csr_dpc = 0x800 -> target 0x800. Immediate wrap: pc = 0xFFFF_FFFC, imm = 8, taken mispredict -> target 0x0000_0004.
- Reset pulsed while in FLUSH with no ack -> req = 0 and ready = 1 right after release. A stray ack in IDLE -> no state change.
- With BRSLV_PERF_CNT_EN defined: 5 branches with 2 mispredicts -> perf_bjp_cnt = 5 and perf_mis_cnt = 2.
